// File: rtl/boxlambda_pad_pkg.sv
// Shared types and helpers for the BoxLambda pad controller.
// Covers the pin mode encoding and the drive decode used per pin.
package boxlambda_pad_pkg;

    typedef enum logic [1:0] {
        PAD_PP   = 2'b00,
        PAD_OD   = 2'b01,
        PAD_IN   = 2'b10,
        PAD_RSVD = 2'b11
    } pad_mode_t;

    typedef struct packed {
        logic oe;
        logic o;
    } pad_drive_t;

    // A filter length of zero would never let the input through, so clamp it to one.
    function automatic int unsigned eff_filter_cycles(input int unsigned cycles);
        return (cycles == 0) ? 1 : cycles;
    endfunction

    function automatic pad_drive_t pad_drive(input pad_mode_t mode, input logic core_o,
                                             input logic core_oe);
        pad_drive_t drv;
        drv = '0;
        case (mode)
            PAD_PP: begin
                drv.oe = core_oe;
                drv.o  = core_o;
            end
            PAD_OD: begin
                drv.oe = ~core_o;
                drv.o  = 1'b0;
            end
            default: drv = '0;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/boxlambda_pad_ctrl_pad_in_filter.sv
// Per-pin input path: two-flop synchroniser, stability filter and edge pulses.
// The stability filter only accepts a new level after it has been held for FILTER_CYCLES samples.
module pad_in_filter
    import boxlambda_pad_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 4,
    parameter logic        RESET_LEVEL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_i,
    output logic sync_o,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned F  = eff_filter_cycles(FILTER_CYCLES);
    localparam int unsigned CW = $clog2(F + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(F - 1);

    logic          s1_q;
    logic          s2_q;
    logic          filt_q;
    logic          filt_d;
    logic          filt_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any sample that agrees with the current level restarts the count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (s2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= RESET_LEVEL;
            s2_q       <= RESET_LEVEL;
            filt_q     <= RESET_LEVEL;
            filt_dly_q <= RESET_LEVEL;
            cnt_q      <= '0;
        end else begin
            s1_q       <= pad_i;
            s2_q       <= s1_q;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            cnt_q      <= cnt_d;
        end
    end

    assign sync_o = s2_q;
    assign filt_o = filt_q;
    assign rise_o = filt_q & ~filt_dly_q;
    assign fall_o = ~filt_q & filt_dly_q;

endmodule

// File: rtl/boxlambda_pad_ctrl.sv
// Pad controller for NUM_PINS bidirectional pins: registered mode-dependent drive toward
// the tristate buffers, filtered input with edge pulses back toward the cores.
module boxlambda_pad_ctrl
    import boxlambda_pad_pkg::*;
#(
    parameter int unsigned NUM_PINS      = 24,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter logic        RESET_LEVEL   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*NUM_PINS-1:0] mode,
    input  logic [NUM_PINS-1:0]   core_o,
    input  logic [NUM_PINS-1:0]   core_oe,
    output logic [NUM_PINS-1:0]   core_i,
    output logic [NUM_PINS-1:0]   rise,
    output logic [NUM_PINS-1:0]   fall,
    input  logic [NUM_PINS-1:0]   pad_i,
    output logic [NUM_PINS-1:0]   pad_o,
    output logic [NUM_PINS-1:0]   pad_oe,
    output logic [NUM_PINS-1:0]   snoop
);

    logic [NUM_PINS-1:0] pad_o_q;
    logic [NUM_PINS-1:0] pad_o_d;
    logic [NUM_PINS-1:0] pad_oe_q;
    logic [NUM_PINS-1:0] pad_oe_d;
    logic [NUM_PINS-1:0] sync2;

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        pad_drive_t drv;

        assign drv         = pad_drive(pad_mode_t'(mode[2*i +: 2]), core_o[i], core_oe[i]);
        assign pad_o_d[i]  = drv.o;
        assign pad_oe_d[i] = drv.oe;

        pad_in_filter #(
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_LEVEL   (RESET_LEVEL)
        ) u_in_filter (
            .clk    (clk),
            .rst    (rst),
            .pad_i  (pad_i[i]),
            .sync_o (sync2[i]),
            .filt_o (core_i[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    // Reset releases every pin at once, without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_o_q  <= '0;
            pad_oe_q <= '0;
        end else begin
            pad_o_q  <= pad_o_d;
            pad_oe_q <= pad_oe_d;
        end
    end

    assign pad_o  = pad_o_q;
    assign pad_oe = pad_oe_q;
    assign snoop  = (pad_oe_q & pad_o_q) | (~pad_oe_q & sync2);

endmodule

// File: tb/tb_boxlambda_pad_ctrl.sv
// Self-checking bench for boxlambda_pad_ctrl: window-based reference model compared every
// cycle, plus directed literal checks of the main scenarios.
module tb_boxlambda_pad_ctrl;

    localparam int N = 24;
    localparam int F = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [2*N-1:0] mode = '0;
    logic [N-1:0]   core_o = '0;
    logic [N-1:0]   core_oe = '0;
    logic [N-1:0]   pad_i = '1;
    logic [N-1:0]   core_i;
    logic [N-1:0]   rise;
    logic [N-1:0]   fall;
    logic [N-1:0]   pad_o;
    logic [N-1:0]   pad_oe;
    logic [N-1:0]   snoop;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    boxlambda_pad_ctrl #(
        .NUM_PINS      (N),
        .FILTER_CYCLES (F),
        .RESET_LEVEL   (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .core_o  (core_o),
        .core_oe (core_oe),
        .core_i  (core_i),
        .rise    (rise),
        .fall    (fall),
        .pad_i   (pad_i),
        .pad_o   (pad_o),
        .pad_oe  (pad_oe),
        .snoop   (snoop)
    );

    always #5 clk = ~clk;

    // Reference model: hist[j] is pad_i as sampled j+1 edges ago (before this edge's shift).
    // The filtered level takes value v once the synchronised samples seen over the last F
    // edges are all v.
    logic [N-1:0] hist [0:F];
    logic [N-1:0] m_filt;
    logic [N-1:0] m_filt_q;
    logic [N-1:0] m_po;
    logic [N-1:0] m_poe;

    always @(posedge clk or posedge rst) begin
        logic [N-1:0] nf;
        bit all0;
        bit all1;
        if (rst) begin
            for (int j = 0; j <= F; j++) hist[j] <= '1;
            m_filt   <= '1;
            m_filt_q <= '1;
            m_po     <= '0;
            m_poe    <= '0;
        end else begin
            nf = m_filt;
            for (int p = 0; p < N; p++) begin
                all0 = 1'b1;
                all1 = 1'b1;
                for (int j = 1; j <= F; j++) begin
                    if (hist[j][p]) all0 = 1'b0;
                    else            all1 = 1'b0;
                end
                if (all1)      nf[p] = 1'b1;
                else if (all0) nf[p] = 1'b0;
            end
            m_filt   <= nf;
            m_filt_q <= m_filt;
            hist[0]  <= pad_i;
            for (int j = 1; j <= F; j++) hist[j] <= hist[j-1];
            for (int p = 0; p < N; p++) begin
                case (mode[2*p +: 2])
                    2'b00:   begin m_poe[p] <= core_oe[p]; m_po[p] <= core_o[p]; end
                    2'b01:   begin m_poe[p] <= ~core_o[p]; m_po[p] <= 1'b0;      end
                    default: begin m_poe[p] <= 1'b0;       m_po[p] <= 1'b0;      end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_rise;
        logic [N-1:0] e_fall;
        logic [N-1:0] e_snoop;
        if (started) begin
            e_rise  = m_filt & ~m_filt_q;
            e_fall  = ~m_filt & m_filt_q;
            e_snoop = (m_poe & m_po) | (~m_poe & hist[1]);
            n_tests++;
            if (core_i !== m_filt || rise !== e_rise || fall !== e_fall ||
                pad_o !== m_po || pad_oe !== m_poe || snoop !== e_snoop) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t core_i=%h/%h rise=%h/%h fall=%h/%h pad_o=%h/%h pad_oe=%h/%h snoop=%h/%h (actual/required)",
                         $time, core_i, m_filt, rise, e_rise, fall, e_fall,
                         pad_o, m_po, pad_oe, m_poe, snoop, e_snoop);
            end
        end
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_pin3(input int cycles, output int lows, output int rises, output int falls);
        lows = 0; rises = 0; falls = 0;
        for (int c = 0; c < cycles; c++) begin
            tick(1);
            if (!core_i[3]) lows++;
            if (rise[3])    rises++;
            if (fall[3])    falls++;
        end
    endtask

    int lows, rises, falls;

    initial begin
        #1 rst = 1'b1;
        started = 1'b1;
        tick(2);
        check("reset_core_i", core_i, 24'hFFFFFF);
        check("reset_pad_oe", pad_oe, 24'h000000);
        check("reset_pad_o", pad_o, 24'h000000);
        check("reset_snoop", snoop, 24'hFFFFFF);
        check("reset_pulses", rise | fall, 24'h000000);
        rst = 1'b0;
        tick(3);

        // All pins fall: core_i must hold for 5 edges and drop on the 6th.
        pad_i = '0;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            check("fall_hold", core_i, 24'hFFFFFF);
        end
        tick(1);
        check("fall_core_i", core_i, 24'h000000);
        check("fall_pulse", fall, 24'hFFFFFF);
        check("fall_no_rise", rise, 24'h000000);
        tick(1);
        check("fall_pulse_end", fall, 24'h000000);
        pad_i = '1;
        tick(10);
        check("recover_core_i", core_i, 24'hFFFFFF);

        // 3-cycle glitch on pin 3 is swallowed.
        pad_i[3] = 1'b0;
        tick(3);
        pad_i[3] = 1'b1;
        count_pin3(16, lows, rises, falls);
        check("glitch3_lows", N'(lows), N'(0));
        check("glitch3_pulses", N'(rises + falls), N'(0));

        // 4-cycle glitch on pin 3 passes through for 4 cycles.
        pad_i[3] = 1'b0;
        tick(4);
        pad_i[3] = 1'b1;
        count_pin3(16, lows, rises, falls);
        check("glitch4_lows", N'(lows), N'(4));
        check("glitch4_rises", N'(rises), N'(1));
        check("glitch4_falls", N'(falls), N'(1));

        // Push-pull drive.
        mode = '0; core_oe = '1; core_o = '1;
        tick(1);
        check("pp_pad_oe", pad_oe, 24'hFFFFFF);
        check("pp_pad_o", pad_o, 24'hFFFFFF);
        check("pp_snoop", snoop, 24'hFFFFFF);

        // Open-drain drive low, then release while pin 0 is stretched low externally.
        mode = {N{2'b01}}; core_o = '0; pad_i = '0;
        tick(1);
        check("od_low_pad_oe", pad_oe, 24'hFFFFFF);
        check("od_low_pad_o", pad_o, 24'h000000);
        core_o = '1; pad_i = 24'hFFFFFE;
        tick(1);
        check("od_release_pad_oe", pad_oe, 24'h000000);
        tick(8);
        check("od_stretch_core_i", core_i, 24'hFFFFFE);
        pad_i = '1;
        tick(8);

        // Input-only and reserved modes never drive.
        mode = {N{2'b10}}; core_oe = '1; core_o = '1;
        tick(1);
        check("in_pad_oe", pad_oe, 24'h000000);
        mode = {N{2'b11}};
        tick(1);
        check("rsvd_pad_oe", pad_oe, 24'h000000);

        // Mixed modes, pin i in mode i%4.
        mode = {6{8'b11_10_01_00}}; core_oe = '1; core_o = 24'hAAAAAA;
        tick(1);
        check("mix_a_pad_oe", pad_oe, 24'h111111);
        check("mix_a_pad_o", pad_o, 24'h000000);
        core_o = 24'h555555;
        tick(1);
        check("mix_b_pad_oe", pad_oe, 24'h333333);
        check("mix_b_pad_o", pad_o, 24'h111111);

        // Pin 5 toggles every cycle; other pins and controls wander.
        for (int c = 0; c < 60; c++) begin
            pad_i[5] = ~pad_i[5];
            if (c % 7 == 0) begin
                mode    = {$urandom, $urandom};
                core_o  = N'($urandom);
                core_oe = N'($urandom);
                pad_i   = (N'($urandom) & ~(N'(1) << 5)) | (pad_i & (N'(1) << 5));
            end
            tick(1);
        end
        check("toggle_pin5", N'(core_i[5]), N'(1));

        // Asynchronous reset while every pin drives.
        mode = '0; core_oe = '1; core_o = '0; pad_i = '0;
        tick(10);
        check("pre_rst_pad_oe", pad_oe, 24'hFFFFFF);
        check("pre_rst_core_i", core_i, 24'h000000);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_pad_oe", pad_oe, 24'h000000);
        pad_i = '1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("post_rst_core_i", core_i, 24'hFFFFFF);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
